ring_counter_gen: RTL and testbench
===================================

// Module: ring_counter_gen
// PURPOSE
//  Parametrised one-hot ring / Johnson shift counter with an internal step prescaler, direction control,
//  synchronous load and ring self-correction. Drives LED chasers, phase/strobe sequencers and slot
//  selectors. The whole block runs on a single clock: the prescaler produces a one-cycle step strobe,
//  and no register is clocked from a derived clock.
// PARAMETERS
//  WIDTH  8   state/output width, >=2
//  DIV_W  21  prescaler width, >=1; one step every 2**DIV_W enabled clk cycles
// PORTS
//  clk       in   1      system clock, all logic on posedge
//  rst       in   1      asynchronous, active-high reset
//  en        in   1      count enable; gates both the prescaler and stepping
//  mode      in   1      0 = ring (rotate), 1 = Johnson (twisted ring)
//  dir       in   1      0 = left (toward MSB), 1 = right (toward LSB)
//  load      in   1      synchronous load strobe
//  load_val  in   WIDTH  value written on load
//  out       out  WIDTH  counter state
//  tick      out  1      one-cycle pulse, high in the cycle a stepped value first appears on out
//  wrap      out  1      one-cycle pulse, high when a step leaves out == SEED (SEED = 1)
//  err       out  1      one-cycle pulse, ring-mode illegal (non-one-hot) state corrected
// BEHAVIOUR
//  - Reset (async, immediate): prescaler = 0, out = SEED ('b0..01), tick = wrap = err = 0.
//  - Prescaler: DIV_W-bit up counter. Increments only when en=1 and load=0; otherwise holds.
//    Wraps from all-ones to 0. Internal step = en & ~load & (cnt == all-ones).
//  - Priority per edge: rst > load > step > hold.
//  - load=1: out <= load_val, prescaler <= 0, tick = wrap = err = 0. load_val is not checked at load.
//  - Step, ring mode:
//    - out exactly one-hot: left out <= {out[W-2:0], out[W-1]}; right out <= {out[0], out[W-1:1]}.
//    - out not one-hot (zero or multi-hot): out <= SEED, err = 1 for one cycle, no rotate.
//  - Step, Johnson mode: left out <= {out[W-2:0], ~out[W-1]}; right out <= {~out[0], out[W-1:1]}.
//    - No correction, err stays 0. Sequence length is 2*WIDTH from any legal Johnson state.
//  - tick, wrap and err are registered alongside out and are high exactly one cycle per step.
//    - wrap = step produced out == SEED, including a correction to SEED.
//    - A load of SEED never raises wrap.
//  - mode and dir are sampled only at the step edge. Changing them between steps is legal; the next
//    step uses the new setting on the current out.
//  - en=0: out and prescaler hold; tick/wrap/err = 0. Re-enabling resumes the count where it stopped.
//  - Latency: the first step after reset or load occurs 2**DIV_W enabled cycles later.
//  - rst asserted mid-operation: all state returns to reset values at once, without waiting for clk.
//    - Release is synchronous-safe: the first counting edge comes after rst falls.
// STRUCTURE
//  - Package ring_ctr_pkg holds:
//    - MODE_RING = 1'b0, MODE_JOHNSON = 1'b1, DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1
//    - function seed(WIDTH) returning 'b1
//    - function is_onehot(vec): exactly one bit set
//  - Sub-module tick_prescaler:
//    - parameter DIV_W; ports clk, rst, en, clr
//    - output strobe, combinational from its counter register
//  - Top level: next-state mux (load / ring / Johnson / correct) plus output registers for out, tick,
//    wrap and err.
// TESTING (WIDTH=8, DIV_W=2 -> one step every 4 enabled cycles)
//  1. rst pulse, en=1, mode=0, dir=0:
//     - out 01,02,04,...,80,01, one value every 4 cycles, tick with each change.
//     - wrap on the 80->01 step only.
//  2. Johnson left from reset: out 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00,01.
//     - wrap on the 00->01 step; err never set.
//     - Then dir=1 from 01: out 00,80,C0,...
//  3. Ring mode, load_val=8'h05: out=05 next edge, no tick.
//     - 4 cycles later out=01, err=1 and wrap=1 for one cycle.
//     - Then load 80, dir=1: out 40,20,...
//  4. en low for 10 cycles mid-sequence (out=10): out stays 10, no tick.
//     - On re-enable the step happens after the remaining prescale count, not a full 4.
//     - load asserted on a strobe edge: out = load_val, tick=0, prescaler restarts at 0.
//  5. rst raised between clk edges while out=40: out=01 and tick=wrap=err=0 before the next edge.
//     - After release, the first step is 4 enabled cycles later.
//  6. Ring mode, load 8'h00 then step: out=01, err=1.
//     - Johnson mode, load 8'h00 then step left: out=01, err=0.

Source files
------------

// File: rtl/ring_ctr_pkg.sv
// rtl/ring_ctr_pkg.sv - shared constants and helpers for the ring/Johnson counter
package ring_ctr_pkg;

  localparam int VEC_W = 64;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;

  function automatic logic [VEC_W-1:0] seed(input int width);
    return (width > 0) ? VEC_W'(1) : '0;
  endfunction

  // Callers zero-extend their vector to VEC_W bits.
  function automatic logic is_onehot(input logic [VEC_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - VEC_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running step prescaler producing a one-cycle strobe
module tick_prescaler #(
  parameter int DIV_W = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic strobe
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Strobe is high during the last count of each period; the top qualifies it with en.
  assign strobe = (cnt_q == {DIV_W{1'b1}});

endmodule

// File: rtl/ring_counter_gen.sv
// rtl/ring_counter_gen.sv - one-hot ring / Johnson counter with prescaler, load and ring correction
module ring_counter_gen
  import ring_ctr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             wrap,
  output logic             err
);

  localparam logic [VEC_W-1:0] SEED_FULL = seed(WIDTH);
  localparam logic [WIDTH-1:0] SEED      = SEED_FULL[WIDTH-1:0];

  logic             strobe;
  logic             step;
  logic [WIDTH-1:0] out_q, out_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (load),
    .strobe (strobe)
  );

  assign step = en & ~load & strobe;

  always_comb begin
    out_d  = out_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      out_d = load_val;
    end else if (step) begin
      tick_d = 1'b1;
      if (mode == MODE_RING) begin
        if (is_onehot(VEC_W'(out_q))) begin
          out_d = (dir == DIR_LEFT) ? {out_q[WIDTH-2:0], out_q[WIDTH-1]}
                                    : {out_q[0], out_q[WIDTH-1:1]};
        end else begin
          // Corrupted ring: restart from the seed instead of rotating garbage.
          out_d = SEED;
          err_d = 1'b1;
        end
      end else begin
        out_d = (dir == DIR_LEFT) ? {out_q[WIDTH-2:0], ~out_q[WIDTH-1]}
                                  : {~out_q[0], out_q[WIDTH-1:1]};
      end
      wrap_d = (out_d == SEED);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= SEED;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign out  = out_q;
  assign tick = tick_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ring_counter_gen.sv
// tb/tb_ring_counter_gen.sv - self-checking bench for ring_counter_gen against an arithmetic model
module tb_ring_counter_gen;

  localparam int W     = 8;
  localparam int DIV_W = 2;
  localparam int DIV   = 1 << DIV_W;
  localparam int MASK  = (1 << W) - 1;
  localparam int TOP   = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic         dir = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] out_w;
  logic         tick_w, wrap_w, err_w;

  int checks = 0;
  int errors = 0;

  int m_out = 1;
  int m_cnt = 0;
  int m_tick = 0, m_wrap = 0, m_err = 0;

  always #5 clk = ~clk;

  ring_counter_gen #(.WIDTH(W), .DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .out      (out_w),
    .tick     (tick_w),
    .wrap     (wrap_w),
    .err      (err_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_val(input int v, input logic md, input logic dr);
    int msb, lsb;
    msb = (v >= TOP) ? 1 : 0;
    lsb = v % 2;
    if (!md) begin
      if ($countones(v) != 1) return 1;
      return dr ? (v / 2) + lsb * TOP : ((v * 2) & MASK) + msb;
    end
    return dr ? (v / 2) + (1 - lsb) * TOP : ((v * 2) & MASK) + (1 - msb);
  endfunction

  function automatic void model_reset();
    m_out = 1; m_cnt = 0; m_tick = 0; m_wrap = 0; m_err = 0;
  endfunction

  function automatic void model_edge();
    m_tick = 0; m_wrap = 0; m_err = 0;
    if (rst) begin
      model_reset();
    end else if (load) begin
      m_out = int'(load_val);
      m_cnt = 0;
    end else if (en) begin
      if (m_cnt == DIV - 1) begin
        m_tick = 1;
        m_err  = (!mode && $countones(m_out) != 1) ? 1 : 0;
        m_out  = next_val(m_out, mode, dir);
        m_wrap = (m_out == 1) ? 1 : 0;
      end
      m_cnt = (m_cnt + 1) % DIV;
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".out"},  32'(out_w),  32'(m_out));
    chk({tag, ".tick"}, 32'(tick_w), 32'(m_tick));
    chk({tag, ".wrap"}, 32'(wrap_w), 32'(m_wrap));
    chk({tag, ".err"},  32'(err_w),  32'(m_err));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  initial begin
    int waited;
    // Reset
    rst = 1'b1;
    #12;
    model_reset();
    check_all("reset");
    rst = 1'b0;

    // 1. Ring left from reset
    en = 1'b1; mode = 1'b0; dir = 1'b0;
    run("ring_left", 4);
    chk("ring_left.first_step", 32'(out_w), 32'h02);
    run("ring_left", 36);

    // 2. Johnson left then right
    rst = 1'b1; @(negedge clk); model_reset(); rst = 1'b0;
    mode = 1'b1;
    run("johnson_left", 16 * DIV);
    chk("johnson_left.full_cycle", 32'(out_w), 32'h01);
    dir = 1'b1;
    run("johnson_right", 3 * DIV);
    chk("johnson_right.c0", 32'(out_w), 32'hC0);

    // 3. Ring load of non-one-hot value, then load 80 rotating right
    mode = 1'b0; dir = 1'b0; load = 1'b1; load_val = 8'h05;
    cyc("load05");
    chk("load05.value", 32'(out_w), 32'h05);
    load = 1'b0;
    run("correct05", DIV);
    chk("correct05.err", 32'(err_w), 32'h1);
    load = 1'b1; load_val = 8'h80; dir = 1'b1;
    cyc("load80");
    load = 1'b0;
    run("ring_right", 3 * DIV);

    // 4. Enable gap mid-period, then load on a strobe edge
    load = 1'b1; load_val = 8'h10; dir = 1'b0;
    cyc("load10");
    load = 1'b0;
    run("pre_gap", 2);
    en = 1'b0;
    run("gap", 10);
    chk("gap.hold", 32'(out_w), 32'h10);
    en = 1'b1;
    run("resume", 2);
    chk("resume.partial_step", 32'(out_w), 32'h20);
    run("resume", 3);
    load = 1'b1; load_val = 8'h04;
    cyc("load_on_strobe");
    chk("load_on_strobe.tick", 32'(tick_w), 32'h0);
    load = 1'b0;
    run("after_load", 2 * DIV);

    // 5. Asynchronous reset between edges
    load = 1'b1; load_val = 8'h40;
    cyc("load40");
    load = 1'b0;
    run("pre_rst", 2);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    waited = 0;
    while (tick_w !== 1'b1 && waited < 3 * DIV) begin
      cyc("post_rst");
      waited++;
    end
    chk("post_rst.latency", 32'(waited), 32'(DIV));

    // 6. Zero loads in both modes
    load = 1'b1; load_val = 8'h00; mode = 1'b0;
    cyc("ring_zero_load");
    load = 1'b0;
    run("ring_zero", DIV);
    chk("ring_zero.err", 32'(err_w), 32'h1);
    load = 1'b1; mode = 1'b1; dir = 1'b0;
    cyc("johnson_zero_load");
    load = 1'b0;
    run("johnson_zero", DIV);
    chk("johnson_zero.out", 32'(out_w), 32'h01);

    // Randomised operation
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 29) == 0);
      load_val = W'($urandom);
      if ($urandom_range(0, 7) == 0) mode = 1'($urandom);
      if ($urandom_range(0, 7) == 0) dir  = 1'($urandom);
      cyc("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
